// File: rtl/axi_lite_cfg_master_if.sv
// AXI4-Lite bus between the configuration initiator and the register block.
// Only the five AXI4-Lite channels live here; command/response stay as plain ports.
interface axi_lite_cfg_master_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi_lite_cfg_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one length-1 AXI
// read or write out, one response back, with a per-state timeout.
module axi_lite_cfg_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  input  logic [3:0]            cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  axi_lite_cfg_master_if.master m_axi,
  output logic [2:0]            dbg_state
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } state_e;

  // Handshakes: a transfer happens on a rising clk edge where valid & ready are
  // both high; every valid/ready here is a flop, never a function of the peer's
  // ready/valid, and each valid holds its payload stable until it transfers.
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic                  awvalid_q, awvalid_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;

  logic timeout_hit;
  logic do_abort;
  logic aw_hs, w_hs, aw_ok, w_ok;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cmd_ready_d   = cmd_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    awaddr_d      = awaddr_q;
    awvalid_d     = awvalid_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    araddr_d      = araddr_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    do_abort      = 1'b0;
    timeout_hit   = (cnt_q == CNT_W'(TIMEOUT - 1));
    aw_hs         = awvalid_q & m_axi.awready;
    w_hs          = wvalid_q & m_axi.wready;
    aw_ok         = aw_done_q | aw_hs;
    w_ok          = w_done_q | w_hs;

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          cnt_d       = '0;
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = WR_REQ;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = RD_REQ;
          end
        end
      end

      // AW and W retire independently; leave only once both have transferred.
      WR_REQ: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_ok && w_ok) begin
          bready_d = 1'b1;
          cnt_d    = '0;
          state_d  = WR_RESP;
        end else if (timeout_hit) begin
          do_abort = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WR_RESP: begin
        if (m_axi.bvalid) begin
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_resp_d    = m_axi.bresp;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b0;
          state_d       = RSP;
        end else if (timeout_hit) begin
          do_abort = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RD_REQ: begin
        if (m_axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          cnt_d     = '0;
          state_d   = RD_RESP;
        end else if (timeout_hit) begin
          do_abort = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RD_RESP: begin
        if (m_axi.rvalid) begin
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_resp_d    = m_axi.rresp;
          rsp_rdata_d   = m_axi.rdata;
          rsp_timeout_d = 1'b0;
          state_d       = RSP;
        end else if (timeout_hit) begin
          do_abort = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d   = 1'b0;
          rsp_timeout_d = 1'b0;
          cmd_ready_d   = 1'b1;
          state_d       = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Abandon the bus entirely; a late slave response is simply ignored.
    if (do_abort) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_timeout_d = 1'b1;
      rsp_resp_d    = 2'b10;
      rsp_rdata_d   = '0;
      state_d       = RSP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      rsp_timeout_q <= 1'b0;
      awaddr_q      <= '0;
      awvalid_q     <= 1'b0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      araddr_q      <= '0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
      awaddr_q      <= awaddr_d;
      awvalid_q     <= awvalid_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      araddr_q      <= araddr_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_resp       = rsp_resp_q;
  assign rsp_timeout    = rsp_timeout_q;
  assign m_axi.awaddr   = awaddr_q;
  assign m_axi.awvalid  = awvalid_q;
  assign m_axi.wdata    = wdata_q;
  assign m_axi.wstrb    = wstrb_q;
  assign m_axi.wvalid   = wvalid_q;
  assign m_axi.bready   = bready_q;
  assign m_axi.araddr   = araddr_q;
  assign m_axi.arvalid  = arvalid_q;
  assign m_axi.rready   = rready_q;
  assign dbg_state      = state_q;

endmodule
